tlb: RTL

- 16-entry, fully associative MIPS32 joint TLB. Sits beside cp0: it takes EntryHi, EntryLo0/1 and Index from cp0, and returns probe and read results in cp0's tlbp_we/index_data and tlbr_we/lo0/lo1/hi_data formats.
- Provides two translation ports: s0 for instruction fetch, s1 for data access. Each reports the physical address and the TLB exception class.
- kseg0/kseg1 are unmapped: the block passes them through without a lookup.

---
 rtl/tlb.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tlb.sv
// 16-entry fully associative MIPS32 joint TLB with two combinational translation ports,
// TLBWI/TLBWR writes, and registered TLBP/TLBR results in cp0's write-back format.
module tlb #(
    parameter int TLBNUM = 16,
    localparam int IDXW = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     s0_vaddr,
    output logic [31:0]     s0_paddr,
    output logic [1:0]      s0_ex,
    input  logic [31:0]     s1_vaddr,
    input  logic            s1_store,
    output logic [31:0]     s1_paddr,
    output logic [1:0]      s1_ex,
    input  logic [7:0]      asid,
    input  logic            tlbwi_we,
    input  logic            tlbwr_we,
    input  logic [IDXW-1:0] w_index,
    input  logic [31:0]     w_hi,
    input  logic [31:0]     w_lo0,
    input  logic [31:0]     w_lo1,
    input  logic            probe_req,
    output logic            tlbp_we,
    output logic [31:0]     index_data,
    input  logic            tlbr_req,
    output logic            tlbr_we,
    output logic [31:0]     lo0_data,
    output logic [31:0]     lo1_data,
    output logic [31:0]     hi_data,
    output logic [IDXW-1:0] random
);
    logic [18:0]     r_vpn2 [TLBNUM];
    logic [7:0]      r_asid [TLBNUM];
    logic            r_g    [TLBNUM];
    logic [19:0]     r_pfn0 [TLBNUM];
    logic [19:0]     r_pfn1 [TLBNUM];
    logic [2:0]      r_c0   [TLBNUM];
    logic [2:0]      r_c1   [TLBNUM];
    logic            r_d0   [TLBNUM];
    logic            r_d1   [TLBNUM];
    logic            r_v0   [TLBNUM];
    logic            r_v1   [TLBNUM];

    logic [IDXW-1:0] r_random;
    logic            r_tlbp_we;
    logic [31:0]     r_index_data;
    logic            r_tlbr_we;
    logic [31:0]     r_lo0_data;
    logic [31:0]     r_lo1_data;
    logic [31:0]     r_hi_data;

    logic [TLBNUM-1:0] w_s0_match, w_s1_match, w_p_match;
    logic              w_s0_hit, w_s1_hit, w_p_hit;
    logic [IDXW-1:0]   w_s0_idx, w_s1_idx, w_p_idx;
    logic              w_wen;
    logic [IDXW-1:0]   w_widx;
    logic [19:0]       w_s0_pfn, w_s1_pfn;
    logic              w_s0_v, w_s1_v, w_s1_d;
    logic              w_unused;

    assign w_unused = ^{w_lo0[31:26], w_lo1[31:26], w_hi[12:8]};

    // Descending scan so the lowest matching index is the one left standing.
    function automatic logic [IDXW:0] pri_enc(input logic [TLBNUM-1:0] m);
        logic [IDXW:0] res;
        res = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (m[i]) res = {1'b1, IDXW'(i)};
        end
        return res;
    endfunction

    always_comb begin
        w_s0_match = '0;
        w_s1_match = '0;
        w_p_match  = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            w_s0_match[i] = (r_vpn2[i] == s0_vaddr[31:13]) && (r_g[i] || r_asid[i] == asid);
            w_s1_match[i] = (r_vpn2[i] == s1_vaddr[31:13]) && (r_g[i] || r_asid[i] == asid);
            w_p_match[i]  = (r_vpn2[i] == w_hi[31:13]) && (r_g[i] || r_asid[i] == w_hi[7:0]);
        end
    end

    assign {w_s0_hit, w_s0_idx} = pri_enc(w_s0_match);
    assign {w_s1_hit, w_s1_idx} = pri_enc(w_s1_match);
    assign {w_p_hit, w_p_idx}   = pri_enc(w_p_match);

    always_comb begin
        w_s0_pfn = s0_vaddr[12] ? r_pfn1[w_s0_idx] : r_pfn0[w_s0_idx];
        w_s0_v   = s0_vaddr[12] ? r_v1[w_s0_idx]   : r_v0[w_s0_idx];
        s0_paddr = {w_s0_pfn, s0_vaddr[11:0]};
        s0_ex    = 2'b00;
        if (s0_vaddr[31:30] == 2'b10) begin
            s0_paddr = {3'b000, s0_vaddr[28:0]};
        end else if (!w_s0_hit) begin
            s0_ex = 2'b01;
        end else if (!w_s0_v) begin
            s0_ex = 2'b10;
        end
    end

    always_comb begin
        w_s1_pfn = s1_vaddr[12] ? r_pfn1[w_s1_idx] : r_pfn0[w_s1_idx];
        w_s1_v   = s1_vaddr[12] ? r_v1[w_s1_idx]   : r_v0[w_s1_idx];
        w_s1_d   = s1_vaddr[12] ? r_d1[w_s1_idx]   : r_d0[w_s1_idx];
        s1_paddr = {w_s1_pfn, s1_vaddr[11:0]};
        s1_ex    = 2'b00;
        if (s1_vaddr[31:30] == 2'b10) begin
            s1_paddr = {3'b000, s1_vaddr[28:0]};
        end else if (!w_s1_hit) begin
            s1_ex = 2'b01;
        end else if (!w_s1_v) begin
            s1_ex = 2'b10;
        end else if (s1_store && !w_s1_d) begin
            s1_ex = 2'b11;
        end
    end

    // TLBWI takes precedence over TLBWR when both fire.
    assign w_wen  = tlbwi_we | tlbwr_we;
    assign w_widx = tlbwi_we ? w_index : r_random;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                r_vpn2[i] <= '0;
                r_asid[i] <= '0;
                r_g[i]    <= 1'b0;
                r_pfn0[i] <= '0;
                r_pfn1[i] <= '0;
                r_c0[i]   <= '0;
                r_c1[i]   <= '0;
                r_d0[i]   <= 1'b0;
                r_d1[i]   <= 1'b0;
                r_v0[i]   <= 1'b0;
                r_v1[i]   <= 1'b0;
            end
        end else if (w_wen) begin
            r_vpn2[w_widx] <= w_hi[31:13];
            r_asid[w_widx] <= w_hi[7:0];
            r_g[w_widx]    <= w_lo0[0] & w_lo1[0];
            r_pfn0[w_widx] <= w_lo0[25:6];
            r_pfn1[w_widx] <= w_lo1[25:6];
            r_c0[w_widx]   <= w_lo0[5:3];
            r_c1[w_widx]   <= w_lo1[5:3];
            r_d0[w_widx]   <= w_lo0[2];
            r_d1[w_widx]   <= w_lo1[2];
            r_v0[w_widx]   <= w_lo0[1];
            r_v1[w_widx]   <= w_lo1[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_random     <= '0;
            r_tlbp_we    <= 1'b0;
            r_index_data <= '0;
            r_tlbr_we    <= 1'b0;
            r_lo0_data   <= '0;
            r_lo1_data   <= '0;
            r_hi_data    <= '0;
        end else begin
            r_random  <= r_random + 1'b1;
            r_tlbp_we <= probe_req;
            r_tlbr_we <= tlbr_req;
            if (probe_req) begin
                r_index_data <= {~w_p_hit, {(31 - IDXW){1'b0}}, w_p_idx};
            end
            if (tlbr_req) begin
                r_lo0_data <= {6'b0, r_pfn0[w_index], r_c0[w_index], r_d0[w_index],
                               r_v0[w_index], r_g[w_index]};
                r_lo1_data <= {6'b0, r_pfn1[w_index], r_c1[w_index], r_d1[w_index],
                               r_v1[w_index], r_g[w_index]};
                r_hi_data  <= {r_vpn2[w_index], 5'b0, r_asid[w_index]};
            end
        end
    end

    assign random     = r_random;
    assign tlbp_we    = r_tlbp_we;
    assign index_data = r_index_data;
    assign tlbr_we    = r_tlbr_we;
    assign lo0_data   = r_lo0_data;
    assign lo1_data   = r_lo1_data;
    assign hi_data    = r_hi_data;
endmodule
